// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Multi-cycle load/store stage for the 8-bit accumulator datapath. A
//   transfer is issued from IDLE, the request is held on the data-memory
//   port until acknowledged, and loads then write the returned value back
//   through the register-file write port. busy stalls fetch meanwhile.
//
//   Optional feature macro: LSU_TIMEOUT_EN
//     When defined, a REQ phase that lasts TIMEOUT cycles without mem_ack
//     aborts through the ERR state and pulses err. When undefined, REQ waits
//     indefinitely and err is tied low.
//
// Ports
//   CLK         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       issue a transfer (sampled only in IDLE)
//   is_load     1 = load, 0 = store (captured with start)
//   addr        memory address (captured with start)
//   store_data  store value (captured with start)
//   dest        write-back register pointer (captured with start)
//   mem_req     memory request, held until mem_ack
//   mem_we      write request, valid with mem_req
//   mem_addr    captured address
//   mem_wdata   captured store data
//   mem_rdata   memory read data, valid with mem_ack
//   mem_ack     memory completion
//   wb_en       one-cycle register-file write strobe (loads)
//   wb_addr     write-back pointer
//   wb_data     last load result
//   done        one-cycle completion pulse
//   busy        high while a transfer is in flight
//   err         one-cycle timeout abort pulse
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int W       = 8,
  parameter int D       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic         is_load,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] store_data,
  input  logic [D-1:0] dest,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         wb_en,
  output logic [D-1:0] wb_addr,
  output logic [W-1:0] wb_data,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]   state_r;
  logic [2:0]   state_nxt_s;
  logic         is_load_r;
  logic [W-1:0] addr_r;
  logic [W-1:0] wdata_r;
  logic [D-1:0] dest_r;
  logic [W-1:0] wb_data_r;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  // The abort decision is made in the last allowed REQ cycle, so the
  // transfer spends exactly TIMEOUT cycles in REQ before ERR.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_r;
`endif

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        // An ack always wins, even in the cycle the timeout would fire.
        if (mem_ack) begin
          if (is_load_r) begin
            state_nxt_s = S_WB;
          end else begin
            state_nxt_s = S_FIN;
          end
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_ERR;
`endif
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WB:    state_nxt_s = S_IDLE;
      S_FIN:   state_nxt_s = S_IDLE;
      S_ERR:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the transfer operands when a start is accepted in IDLE.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      is_load_r <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      dest_r    <= '0;
    end else if ((state_r == S_IDLE) && start) begin
      is_load_r <= is_load;
      addr_r    <= addr;
      wdata_r   <= store_data;
      dest_r    <= dest;
    end
  end

  // Load result register; only an acknowledged load updates it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wb_data_r <= '0;
    end else if ((state_r == S_REQ) && mem_ack && is_load_r) begin
      wb_data_r <= mem_rdata;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Cycles spent in REQ without ack; held at zero outside REQ so it is
  // clear on every entry.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (state_r != S_REQ) begin
      cnt_r <= '0;
    end else if (!mem_ack) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign err = (state_r == S_ERR);
`else
  assign err = 1'b0;
`endif

  // Outputs are either flops or pure state decodes, so reset clears them
  // combinationally without waiting for a clock edge.
  assign mem_req   = (state_r == S_REQ);
  assign mem_we    = mem_req & ~is_load_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign wb_en     = (state_r == S_WB);
  assign wb_addr   = dest_r;
  assign wb_data   = wb_data_r;
  assign done      = (state_r == S_WB) || (state_r == S_FIN);
  assign busy      = (state_r != S_IDLE);

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store stage for the 8-bit accumulator datapath.
- Consumes the register file's read ports: the address comes from data_outA (rs) and store data from data_outB (r0).
- Drives a request/acknowledge data-memory interface.
- Produces the write-back data, enable and destination that feed the register file's write port.
- Stalls the fetch stage via busy while a transfer is outstanding.

Parameters:
- W, 8, data/address path width.
- D, 4, register pointer width.
- TIMEOUT, 15, max REQ cycles without mem_ack before abort; only used with LSU_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue a transfer; sampled only in IDLE.
- is_load  input  1  1 = load (mem to reg), 0 = store (reg to mem); captured with start.
- addr  input  W  memory address (from data_outA); captured with start.
- store_data  input  W  store value (from data_outB); captured with start.
- dest  input  D  write-back register pointer; captured with start.
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  1 = write request; valid while mem_req=1.
- mem_addr  output  W  captured address; valid while mem_req=1.
- mem_wdata  output  W  captured store data; valid while mem_req=1.
- mem_rdata  input  W  read data; valid in the cycle mem_ack=1.
- mem_ack  input  1  memory completion; may be asserted in the first REQ cycle.
- wb_en  output  1  one-cycle register-file write strobe (loads only).
- wb_addr  output  D  write-back pointer.
- wb_data  output  W  load result.
- done  output  1  one-cycle completion pulse (load or store).
- busy  output  1  high whenever state != IDLE.
- err  output  1  one-cycle abort pulse (timeout); constant 0 without LSU_TIMEOUT_EN.

Behaviour:
- States: IDLE, REQ, WB, FIN, ERR. All outputs are registered or decoded from state.
- Reset (async): state=IDLE. The following all clear to 0 immediately, including mid-transfer: mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr, wb_data, done, busy, err, timeout counter.
- IDLE, start=1:
  - Capture addr, store_data, dest, is_load.
  - Next state REQ.
  - start=0 stays in IDLE.
  - mem_ack in IDLE is ignored.
- REQ:
  - mem_req=1; mem_we=~is_load; mem_addr/mem_wdata = captured values, stable for the whole state.
  - On mem_ack=1 with a load: latch mem_rdata into wb_data, next state WB.
  - On mem_ack=1 with a store: next state FIN.
  - On mem_ack=0: stay in REQ.
- WB:
  - wb_en=1, done=1, wb_addr=captured dest, for exactly one cycle.
  - Next state IDLE.
- FIN:
  - done=1, wb_en=0, for one cycle.
  - Next state IDLE.
- Latency: with ack in the first REQ cycle, start at edge N gives REQ in cycle N+1 and WB/FIN in cycle N+2. Next start is accepted at N+3 at the earliest (3-cycle issue interval).
- start while busy=1 is ignored and nothing is queued.
- wb_data holds its last load value until the next load or reset. Stores never modify it.
- A simultaneous start and mem_ack in IDLE starts the transfer; the stray ack is not consumed.
- mem_ack held high across cycles counts once; leftover ack cycles after leaving REQ are ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT with mem_ack=0, next state is ERR.
  - ERR: err=1 for one cycle, done=0, wb_en=0, mem_req=0, then IDLE.
  - An ack arriving in the cycle the count reaches TIMEOUT wins and completes normally.
- Undefined:
  - REQ waits indefinitely.
  - err tied 0.
  - No counter is instantiated.

Test Plan:
- Reset mid-REQ: issue load addr=0x10, assert reset while mem_req=1 -> mem_req, busy and all outputs drop to 0 the same cycle, before the next clock edge; after release, state is IDLE.
- Load, immediate ack: start, is_load=1, addr=0x2A, dest=5; memory acks in the first REQ cycle with rdata=0xC3 -> mem_we=0, mem_addr=0x2A; two edges after start, wb_en=1, wb_addr=5, wb_data=0xC3, done=1 for one cycle; busy low the following cycle.
- Store, 3-cycle wait: start, is_load=0, addr=0x07, store_data=0x5E; ack after 3 REQ cycles -> mem_req=1, mem_we=1, mem_wdata=0x5E held stable for all 3 cycles; FIN gives done=1, wb_en=0; wb_data unchanged.
- Start while busy: second start (addr=0x99) pulsed during REQ of a load to 0x01 -> mem_addr stays 0x01; exactly one done pulse; no second request issued.
- Back-to-back: loads to 0x00 then 0x01, each start raised the cycle busy falls -> two wb_en pulses 3 cycles apart, correct data each.
- Timeout (LSU_TIMEOUT_EN, TIMEOUT=4): load with mem_ack never asserted -> err=1 for one cycle after 4 REQ cycles, wb_en=0, done=0, return to IDLE. Repeat with ack in the 4th cycle -> normal WB, err=0. Without macro, no ack -> busy stays 1 for 50+ cycles, err=0.
